// File: rtl/pdm_mic_decimator.sv
// ============================================================================
// Module   : pdm_mic_decimator (with helper pdm_cic2)
// Purpose  : Generates the PDM microphone clock and samples the 1-bit PDM
//            stream. It decimates the stream with an order-2 CIC filter and
//            emits 8-bit unsigned PCM samples, each with a one-cycle valid
//            strobe.
// Ports    : clk_in       system clock
//            rst_in       synchronous reset, active-low
//            en_in        capture enable
//            m_data_in    PDM data from mic (asynchronous, synchronized here)
//            m_clk_out    mic clock
//            sample_out   decimated PCM sample (left / mono)
//            valid_out    one-cycle strobe, sample_out valid
//            sample_r_out right-channel sample     (PDM_STEREO_EN only)
//            valid_r_out  right-channel strobe     (PDM_STEREO_EN only)
// Options  : define PDM_STEREO_EN to add the falling-edge right channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Order-2 CIC with frame counter and output mapping. One instance per channel.
module pdm_cic2 #(
  parameter int DECIM = 64
) (
  input  logic       clk_in,
  input  logic       rst_in,   // synchronous, active-low
  input  logic       clear,    // synchronous filter clear (idle / disable)
  input  logic       step,     // PDM sample strobe
  input  logic       bit_in,   // synchronized PDM bit
  output logic       done,     // this strobe completes a frame
  output logic [7:0] pcm       // mapped output for the completing frame
);
  localparam int L     = $clog2(DECIM);
  localparam int W     = 2 * L + 1;
  localparam int SHIFT = 2 * L - 8;

  logic [L-1:0] frame_cnt;
  logic [W-1:0] i1, i2, d1, d2;
  logic [W-1:0] i1_nx, i2_nx, c1, y, ysat;

  always_comb begin
    i1_nx = i1 + W'(bit_in);
    i2_nx = i2 + i1_nx;
    c1    = i2_nx - d1;
    y     = c1 - d2;
    // y never exceeds DECIM^2, so the top bit alone marks the one value
    // that needs clamping to DECIM^2-1.
    ysat  = y[W-1] ? {1'b0, {(W-1){1'b1}}} : y;
    pcm   = 8'(ysat >> SHIFT);
    done  = step && (frame_cnt == L'(DECIM - 1));
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in || clear) begin
      frame_cnt <= '0;
      i1        <= '0;
      i2        <= '0;
      d1        <= '0;
      d2        <= '0;
    end else if (step) begin
      i1        <= i1_nx;
      i2        <= i2_nx;
      frame_cnt <= frame_cnt + L'(1);
      if (done) begin
        d1 <= i2_nx;
        d2 <= c1;
      end
    end
  end
endmodule

module pdm_mic_decimator #(
  parameter int CLK_DIV       = 40,
  parameter int DECIM         = 64,
  parameter int SETTLE_FRAMES = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       en_in,
  input  logic       m_data_in,
  output logic       m_clk_out,
  output logic [7:0] sample_out,
`ifdef PDM_STEREO_EN
  output logic [7:0] sample_r_out,
  output logic       valid_r_out,
`endif
  output logic       valid_out
);
  localparam int DW   = $clog2(CLK_DIV);
  localparam int HALF = CLK_DIV / 2;
  localparam int SW   = $clog2(SETTLE_FRAMES + 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t         state;
  logic           sync1, sync2;
  logic [DW-1:0]  div_cnt;
  logic [SW-1:0]  settle_cnt;
  logic           active, clear, rise_stb, fall_stb, done_l;
  logic [7:0]     pcm_l;

  always_comb begin
    active   = (state != IDLE) && en_in;
    // Dropping en_in clears the filter in the same edge the FSM returns to
    // IDLE, so a partial frame can never complete.
    clear    = !active;
    rise_stb = active && (div_cnt == DW'(HALF - 1));
    fall_stb = active && (div_cnt == DW'(CLK_DIV - 1));
  end

  pdm_cic2 #(.DECIM(DECIM)) u_cic_l (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (clear),
    .step   (rise_stb),
    .bit_in (sync2),
    .done   (done_l),
    .pcm    (pcm_l)
  );

`ifdef PDM_STEREO_EN
  logic       done_r, left_seen;
  logic [7:0] pcm_r;

  pdm_cic2 #(.DECIM(DECIM)) u_cic_r (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (clear),
    .step   (fall_stb),
    .bit_in (sync2),
    .done   (done_r),
    .pcm    (pcm_r)
  );
`endif

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      div_cnt    <= '0;
      settle_cnt <= '0;
      m_clk_out  <= 1'b0;
      sample_out <= 8'd0;
      valid_out  <= 1'b0;
`ifdef PDM_STEREO_EN
      sample_r_out <= 8'd0;
      valid_r_out  <= 1'b0;
      left_seen    <= 1'b0;
`endif
    end else begin
      sync1     <= m_data_in;
      sync2     <= sync1;
      valid_out <= 1'b0;
`ifdef PDM_STEREO_EN
      valid_r_out <= 1'b0;
`endif
      if (!active) begin
        m_clk_out  <= 1'b0;
        div_cnt    <= '0;
        settle_cnt <= '0;
`ifdef PDM_STEREO_EN
        left_seen  <= 1'b0;
`endif
        if (state == IDLE) begin
          if (en_in) state <= (SETTLE_FRAMES == 0) ? RUN : SETTLE;
        end else begin
          state <= IDLE;
        end
      end else begin
        div_cnt <= (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + DW'(1);
        if (rise_stb) m_clk_out <= 1'b1;
        if (fall_stb) m_clk_out <= 1'b0;

        if (done_l) begin
          if (state == RUN) begin
            sample_out <= pcm_l;
            valid_out  <= 1'b1;
`ifdef PDM_STEREO_EN
            left_seen  <= 1'b1;
`endif
          end else if (settle_cnt == SW'(SETTLE_FRAMES - 1)) begin
            state <= RUN;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end

`ifdef PDM_STEREO_EN
        // Right frames trail left frames by half a mic clock; waiting for
        // the first emitted left frame keeps the two outputs paired.
        if (done_r && state == RUN && left_seen) begin
          sample_r_out <= pcm_r;
          valid_r_out  <= 1'b1;
        end
`endif
      end
    end
  end
endmodule

`default_nettype wire
